// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stall/flush requests in, per-stage enables and valids out,
// plus the performance-counter read port.
interface pipe_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int NSRC    = 5,
  parameter int SW      = $clog2(NSTAGES),
  parameter int CNT_W   = 32
);
  localparam int CSW = $clog2(NSRC + 1);

  logic [NSRC-1:0]    stall_req;
  logic               flush_req;
  logic [SW-1:0]      flush_stage;
  logic               fetch_valid;
  logic [NSTAGES-1:0] stage_en;
  logic [NSTAGES-1:0] stage_valid;
  logic               flush_ack;
  logic               wb_valid;
  logic [CSW-1:0]     cnt_sel;
  logic               cnt_clr;
  logic [CNT_W-1:0]   cnt_rdata;

  modport master (
    output stall_req, flush_req, flush_stage, fetch_valid, cnt_sel, cnt_clr,
    input  stage_en, stage_valid, flush_ack, wb_valid, cnt_rdata
  );

  modport slave (
    input  stall_req, flush_req, flush_stage, fetch_valid, cnt_sel, cnt_clr,
    output stage_en, stage_valid, flush_ack, wb_valid, cnt_rdata
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush/valid controller for an NSTAGES-deep in-order pipeline.
// Optional stall/retire counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int                      NSTAGES   = 5,
  parameter int                      NSRC      = 5,
  parameter int                      SW        = $clog2(NSTAGES),
  parameter logic [NSRC*SW-1:0]      SRC_STAGE = {3'd3, 3'd3, 3'd2, 3'd1, 3'd1},
  parameter int                      CNT_W     = 32
) (
  input  logic      clock,
  input  logic      reset,
  pipe_ctrl_if.slave bus
);
  logic [NSTAGES-1:0] r_stage_valid;
  logic [NSTAGES-1:0] w_valid_nxt;
  logic [NSTAGES-1:0] w_hold;
  logic [NSTAGES-1:0] w_prev_hold;
  logic [NSTAGES-1:0] w_prev_valid;
  logic [NSTAGES-1:0] w_flush_mask;
  logic               w_hold_fs;
  logic               w_flush_ok;

  // w_hold[i] is set for every stage at or below the deepest requested freeze point.
  always_comb begin
    w_hold       = '0;
    w_hold_fs    = 1'b0;
    w_flush_mask = '0;
    for (int j = 0; j < NSRC; j++) begin
      if (bus.stall_req[j]) begin
        for (int i = 0; i < NSTAGES; i++) begin
          if (int'(SRC_STAGE[j*SW +: SW]) >= i) w_hold[i] = 1'b1;
        end
        if (SRC_STAGE[j*SW +: SW] >= bus.flush_stage) w_hold_fs = 1'b1;
      end
    end
    w_flush_ok = bus.flush_req && !w_hold_fs;
    for (int i = 0; i < NSTAGES; i++) begin
      w_flush_mask[i] = w_flush_ok && (i < int'(bus.flush_stage));
    end
  end

  assign w_prev_hold  = {w_hold[NSTAGES-2:0], 1'b0};
  assign w_prev_valid = {r_stage_valid[NSTAGES-2:0], bus.fetch_valid};

  // Priority per stage: flush kill, hold, bubble below a frozen stage, advance.
  always_comb begin
    w_valid_nxt = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (w_flush_mask[i])      w_valid_nxt[i] = 1'b0;
      else if (w_hold[i])       w_valid_nxt[i] = r_stage_valid[i];
      else if (w_prev_hold[i])  w_valid_nxt[i] = 1'b0;
      else                      w_valid_nxt[i] = w_prev_valid[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_stage_valid <= '0;
    else       r_stage_valid <= w_valid_nxt;
  end

  assign bus.stage_en    = reset ? '1 : (~w_hold | w_flush_mask);
  assign bus.flush_ack   = w_flush_ok && !reset;
  assign bus.stage_valid = r_stage_valid;
  assign bus.wb_valid    = r_stage_valid[NSTAGES-1];

`ifdef PIPE_CTRL_PERF_EN
  localparam int NCNT = NSRC + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] r_cnt [NCNT];
  logic [CNT_W-1:0] w_cnt_nxt [NCNT];
  logic [NCNT-1:0]  w_inc;
  logic [CNT_W-1:0] w_sel_nxt;
  logic [CNT_W-1:0] r_cnt_rdata;

  // The read register captures the post-update value, so a clear shows up one cycle later.
  always_comb begin
    w_inc     = {r_stage_valid[NSTAGES-1], bus.stall_req};
    w_sel_nxt = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (bus.cnt_clr)   w_cnt_nxt[k] = '0;
      else if (w_inc[k]) w_cnt_nxt[k] = sat_inc(r_cnt[k]);
      else               w_cnt_nxt[k] = r_cnt[k];
      if (int'(bus.cnt_sel) == k) w_sel_nxt = w_cnt_nxt[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCNT; k++) r_cnt[k] <= '0;
      r_cnt_rdata <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) r_cnt[k] <= w_cnt_nxt[k];
      r_cnt_rdata <= w_sel_nxt;
    end
  end

  assign bus.cnt_rdata = r_cnt_rdata;
`else
  logic w_unused_perf;
  assign w_unused_perf = ^{bus.cnt_sel, bus.cnt_clr};
  assign bus.cnt_rdata = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: driver queues expectations, monitor checks at negedge.
module tb_pipe_ctrl;
  localparam int NST   = 5;
  localparam int NSRC  = 5;
  localparam int SW    = 3;
  localparam int CNT_W = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [4:0] en;
    logic       ack;
    logic [4:0] vld;
    bit         cv;
    logic [3:0] cnt;
    bit         cc;
    string      nm;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clock = ~clock;

  pipe_ctrl_if #(.NSTAGES(NST), .NSRC(NSRC), .SW(SW), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .NSTAGES(NST), .NSRC(NSRC), .SW(SW),
    .SRC_STAGE(15'b011_011_010_001_001), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%0h expected=%0h", nm, what, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "stage_en", 32'(bus.stage_en), 32'(e.en));
      chk(e.nm, "flush_ack", 32'(bus.flush_ack), 32'(e.ack));
      if (e.cv) begin
        chk(e.nm, "stage_valid", 32'(bus.stage_valid), 32'(e.vld));
        chk(e.nm, "wb_valid", 32'(bus.wb_valid), 32'(e.vld[4]));
      end
      if (e.cc) chk(e.nm, "cnt_rdata", 32'(bus.cnt_rdata), 32'(e.cnt));
    end
  end

  function automatic logic [3:0] ecnt(input int v);
    return PERF ? 4'(v) : 4'd0;
  endfunction

  // One cycle of stimulus plus what the DUT must show during that cycle.
  task automatic c(input logic r, input logic [4:0] st, input logic fr, input logic [2:0] fs,
                   input logic fv, input logic [2:0] sel, input logic clr,
                   input logic [4:0] een, input logic eack, input logic [4:0] evld, input bit cv,
                   input int ec, input bit cc, input string nm);
    exp_t x;
    @(posedge clock);
    #1;
    reset           = r;
    bus.stall_req   = st;
    bus.flush_req   = fr;
    bus.flush_stage = fs;
    bus.fetch_valid = fv;
    bus.cnt_sel     = sel;
    bus.cnt_clr     = clr;
    x.en = een; x.ack = eack; x.vld = evld; x.cv = cv;
    x.cnt = ecnt(ec); x.cc = cc; x.nm = nm;
    sb.push_back(x);
  endtask

  initial begin
    logic [4:0] fillv [6];
    logic [4:0] seqv  [5];
    int t;
    fillv = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    seqv  = '{5'b11000, 5'b10001, 5'b00011, 5'b00111, 5'b01111};
    reset = 1'b1;
    bus.stall_req = '0; bus.flush_req = 1'b0; bus.flush_stage = '0;
    bus.fetch_valid = 1'b0; bus.cnt_sel = '0; bus.cnt_clr = 1'b1;

    // reset overrides stall and flush requests
    c(1, 5'b11111, 1, 3'd1, 1, 3'd0, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, "rst0");
    c(1, 5'b11111, 1, 3'd1, 1, 3'd0, 1, 5'b11111, 0, 5'b00000, 1, 0, 1, "rst1");

    for (int k = 0; k < 6; k++)
      c(0, 5'b00000, 0, 3'd0, 1, 3'd0, 1, 5'b11111, 0, fillv[k], 1, 0, 1, "fill");

    c(0, 5'b01000, 0, 3'd0, 1, 3'd0, 1, 5'b10000, 0, 5'b11111, 1, 0, 1, "stall3_a");
    c(0, 5'b01000, 0, 3'd0, 1, 3'd0, 1, 5'b10000, 0, 5'b01111, 1, 0, 1, "stall3_b");
    c(0, 5'b01000, 0, 3'd0, 1, 3'd0, 1, 5'b10000, 0, 5'b01111, 1, 0, 1, "stall3_c");
    c(0, 5'b00000, 0, 3'd0, 1, 3'd0, 1, 5'b11111, 0, 5'b01111, 1, 0, 1, "stall3_rel");

    c(0, 5'b00000, 1, 3'd1, 1, 3'd0, 1, 5'b11111, 1, 5'b11111, 1, 0, 1, "flush1");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd0, 1, 5'b11111, 0, 5'b11110, 1, 0, 1, "flush1_after");
    c(0, 5'b00000, 1, 3'd3, 1, 3'd0, 1, 5'b11111, 1, 5'b11100, 1, 0, 1, "flush3");
    for (int k = 0; k < 5; k++)
      c(0, 5'b00000, 0, 3'd0, 1, 3'd0, 1, 5'b11111, 0, seqv[k], 1, 0, 1, "refill");

    c(0, 5'b00100, 1, 3'd1, 1, 3'd0, 1, 5'b11000, 0, 5'b11111, 1, 0, 1, "flush_blocked");
    c(0, 5'b00000, 1, 3'd1, 1, 3'd0, 1, 5'b11111, 1, 5'b10111, 1, 0, 1, "flush_unblocked");
    c(0, 5'b00000, 0, 3'd0, 1, 3'd0, 1, 5'b11111, 0, 5'b01110, 1, 0, 1, "post_flush");
    c(0, 5'b00001, 1, 3'd3, 1, 3'd0, 1, 5'b11111, 1, 5'b11101, 1, 0, 1, "flush_over_stall");
    c(0, 5'b10010, 0, 3'd0, 1, 3'd0, 1, 5'b10000, 0, 5'b11000, 1, 0, 1, "multi_src_depth");
    c(0, 5'b00011, 0, 3'd0, 1, 3'd0, 1, 5'b11100, 0, 5'b01000, 1, 0, 1, "same_stage_src");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd0, 1, 5'b11111, 0, 5'b10000, 1, 0, 1, "drain");

    // counters: saturation, clear, retire count
    c(1, 5'b00000, 0, 3'd0, 0, 3'd0, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "perf_rst");
    for (int k = 0; k <= 20; k++)
      c(0, 5'b00001, 0, 3'd0, 0, 3'd0, 0, 5'b11100, 0, 5'b00000, 1, (k > 15) ? 15 : k, 1, "stall_cnt");
    c(0, 5'b00001, 0, 3'd0, 0, 3'd0, 1, 5'b11100, 0, 5'b00000, 1, 15, 1, "cnt_clr");
    c(0, 5'b00001, 0, 3'd0, 0, 3'd0, 0, 5'b11100, 0, 5'b00000, 1, 0, 1, "cnt_cleared");
    c(0, 5'b00000, 0, 3'd0, 1, 3'd5, 0, 5'b11111, 0, 5'b00000, 1, 1, 1, "cnt_recount");
    for (int k = 1; k < 6; k++)
      c(0, 5'b00000, 0, 3'd0, 1, 3'd5, 0, 5'b11111, 0, fillv[k], 1, 0, 1, "retire_fill");
    c(0, 5'b00000, 0, 3'd0, 1, 3'd5, 0, 5'b11111, 0, 5'b11111, 1, 1, 1, "retire1");
    c(0, 5'b00000, 0, 3'd0, 1, 3'd5, 0, 5'b11111, 0, 5'b11111, 1, 2, 1, "retire2");

    // reset in the middle of a stall with a full pipe
    c(0, 5'b01000, 0, 3'd0, 1, 3'd0, 0, 5'b10000, 0, 5'b11111, 1, 3, 1, "pre_rst_stall");
    c(1, 5'b01000, 1, 3'd1, 1, 3'd0, 0, 5'b11111, 0, 5'b01111, 1, 1, 1, "rst_mid_a");
    c(1, 5'b01000, 1, 3'd1, 1, 3'd0, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "rst_mid_b");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd0, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "post_rst");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd5, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "post_rst_c0");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd3, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "post_rst_ret");
    c(0, 5'b00000, 0, 3'd0, 0, 3'd0, 0, 5'b11111, 0, 5'b00000, 1, 0, 1, "post_rst_c3");

    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
